index_alloc_arbiter: RTL



---
 rtl/index_alloc_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/index_alloc_arbiter.sv
// index_alloc_arbiter: round-robin, credit-capped front end for a shared free-list index buffer.
// Latency: acquire handshake and index are combinational; the released entry is registered (1 cycle).
// Backpressure: out_ready low stalls releases via rel_ready; buf_full or spent credit stalls acquires. Optional macro: INDEX_ARB_PERF_EN.
module index_alloc_arbiter #(
    parameter int NUM_REQS        = 4,
    parameter int DATAW           = 32,
    parameter int SIZE            = 16,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDRW           = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int REQ_SELW        = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid,
    input  logic [NUM_REQS-1:0][DATAW-1:0]     req_data,
    output logic [NUM_REQS-1:0]                req_ready,
    output logic [ADDRW-1:0]                   req_index,
    output logic                               buf_acquire_en,
    output logic [REQ_SELW+DATAW-1:0]          buf_write_data,
    input  logic [ADDRW-1:0]                   buf_write_addr,
    input  logic                               buf_full,
    input  logic                               buf_empty,
    input  logic                               rel_valid,
    input  logic [ADDRW-1:0]                   rel_addr,
    output logic                               rel_ready,
    output logic [ADDRW-1:0]                   buf_read_addr,
    input  logic [REQ_SELW+DATAW-1:0]          buf_read_data,
    output logic                               buf_release_en,
    output logic                               out_valid,
    output logic [DATAW-1:0]                   out_data,
    output logic [REQ_SELW-1:0]                out_owner,
    input  logic                               out_ready
`ifdef INDEX_ARB_PERF_EN
    ,
    output logic [31:0]                        perf_stall_full,
    output logic [31:0]                        perf_stall_credit
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [REQ_SELW-1:0] owner;
        logic [DATAW-1:0]    payload;
    } entry_t;

    logic [REQ_SELW-1:0] rr_ptr;
    logic [CW-1:0]       credit [NUM_REQS];
    logic [NUM_REQS-1:0] credit_ok;
    logic [NUM_REQS-1:0] eligible;
    logic [REQ_SELW-1:0] win;
    logic                win_found;
    logic                acq_fire;
    logic                rel_fire;
    int                  rr_idx;
    entry_t              wr_ent;
    entry_t              rd_ent;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            credit_ok[i] = (credit[i] < CW'(MAX_OUTSTANDING));
            eligible[i]  = req_valid[i] && credit_ok[i];
        end
    end

    // Search upward from rr_ptr, wrapping, for the first eligible requester.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        rr_idx    = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            rr_idx = int'(rr_ptr) + k;
            if (rr_idx >= NUM_REQS) rr_idx = rr_idx - NUM_REQS;
            if (!win_found && eligible[rr_idx]) begin
                win_found = 1'b1;
                win       = REQ_SELW'(rr_idx);
            end
        end
    end

    assign acq_fire       = !reset && win_found && !buf_full;
    assign buf_acquire_en = acq_fire;
    assign req_index      = buf_write_addr;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = acq_fire && (win == REQ_SELW'(i));
        end
    end

    assign wr_ent.owner   = win;
    assign wr_ent.payload = req_data[win];
    assign buf_write_data = wr_ent;

    assign rel_ready      = !reset && (!out_valid || out_ready);
    assign rel_fire       = rel_valid && rel_ready;
    assign buf_release_en = rel_fire;
    assign buf_read_addr  = rel_addr;
    assign rd_ent         = buf_read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (acq_fire) begin
            rr_ptr <= (win == REQ_SELW'(NUM_REQS - 1)) ? '0 : win + REQ_SELW'(1);
        end
    end

    // Acquire and release hitting the same requester cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (reset) begin
                credit[i] <= '0;
            end else begin
                if (acq_fire && (win == REQ_SELW'(i)) &&
                    !(rel_fire && (rd_ent.owner == REQ_SELW'(i)))) begin
                    credit[i] <= credit[i] + CW'(1);
                end else if (rel_fire && (rd_ent.owner == REQ_SELW'(i)) &&
                             !(acq_fire && (win == REQ_SELW'(i))) &&
                             (credit[i] != '0)) begin
                    credit[i] <= credit[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_owner <= '0;
        end else if (rel_fire) begin
            out_valid <= 1'b1;
            out_data  <= rd_ent.payload;
            out_owner <= rd_ent.owner;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef INDEX_ARB_PERF_EN
    logic stall_full;
    logic stall_credit;

    assign stall_full   = (|eligible) && buf_full;
    assign stall_credit = |(req_valid & ~credit_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_full   <= '0;
            perf_stall_credit <= '0;
        end else begin
            if (stall_full && (perf_stall_full != '1)) begin
                perf_stall_full <= perf_stall_full + 32'd1;
            end
            if (stall_credit && (perf_stall_credit != '1)) begin
                perf_stall_credit <= perf_stall_credit + 32'd1;
            end
        end
    end
`endif

    // A release must name an allocated entry: its owner holds credit and the buffer is not empty.
    a_rel_owner_has_credit: assert property (@(posedge clk) disable iff (reset)
        rel_fire |-> (credit[rd_ent.owner] != '0));
    a_rel_not_empty: assert property (@(posedge clk) disable iff (reset)
        rel_fire |-> !buf_empty);

endmodule
